// File: rtl/pll_lock_sequencer.sv
// ============================================================================
// Module   : pll_lock_sequencer
// Purpose  : Power-up / relock sequencer for the iCE40UP PLL_CORE. Optional
//            build macro PLL_SEQ_BYPASS_ON_FAIL_EN runs the design from the
//            bypassed reference clock once all lock attempts fail.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pll_lock_sequencer #(
  parameter int CNT_W               = 16,
  parameter int RESET_HOLD_CYCLES   = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 50000,
  parameter int LOCK_STABLE_CYCLES  = 256,
  parameter int MAX_RETRIES         = 3
) (
  input  logic       REFERENCECLK,
  input  logic       RESET,
  input  logic       ENABLE,
  input  logic       PLL_LOCK,
  output logic       PLL_RESETB,
  output logic       PLL_BYPASS,
  output logic       CLK_READY,
  output logic       SYS_RESET,
  output logic       FAULT,
  output logic [2:0] STATE,
  output logic [1:0] RETRY_CNT
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_HOLD      = 3'd1,
    ST_WAIT_LOCK = 3'd2,
    ST_STABLE    = 3'd3,
    ST_RUN       = 3'd4,
    ST_FAIL      = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] C_HOLD_LAST    = CNT_W'(RESET_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_CNT_ONE      = CNT_W'(1);
  localparam logic [1:0]       C_RETRY_MAX    = 2'(MAX_RETRIES);

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic [1:0]       retry;
  logic [1:0]       retry_next;
  logic             lock_meta;
  logic             lock_s;

  // PLL LOCK is asynchronous to REFERENCECLK
  always_ff @(posedge REFERENCECLK or posedge RESET) begin
    if (RESET) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
    end else begin
      lock_meta <= PLL_LOCK;
      lock_s    <= lock_meta;
    end
  end

  always_ff @(posedge REFERENCECLK or posedge RESET) begin
    if (RESET) begin
      state <= ST_IDLE;
      cnt   <= '0;
      retry <= 2'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      retry <= retry_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    retry_next = retry;
    case (state)
      ST_IDLE: begin
        cnt_next   = '0;
        retry_next = 2'd0;
        state_next = ST_HOLD;
      end
      ST_HOLD: begin
        if (cnt == C_HOLD_LAST) begin
          state_next = ST_WAIT_LOCK;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + C_CNT_ONE;
        end
      end
      ST_WAIT_LOCK: begin
        if (lock_s) begin
          state_next = ST_STABLE;
          cnt_next   = '0;
        end else if (cnt == C_TIMEOUT_LAST) begin
          cnt_next = '0;
          if (retry < C_RETRY_MAX) begin
            state_next = ST_HOLD;
            retry_next = retry + 2'd1;
          end else begin
            state_next = ST_FAIL;
          end
        end else begin
          cnt_next = cnt + C_CNT_ONE;
        end
      end
      ST_STABLE: begin
        // A lock dropout restarts the wait without spending a retry
        if (!lock_s) begin
          state_next = ST_WAIT_LOCK;
          cnt_next   = '0;
        end else if (cnt == C_STABLE_LAST) begin
          state_next = ST_RUN;
          cnt_next   = '0;
          retry_next = 2'd0;
        end else begin
          cnt_next = cnt + C_CNT_ONE;
        end
      end
      ST_RUN: begin
        cnt_next   = '0;
        retry_next = 2'd0;
        if (!lock_s) begin
          state_next = ST_HOLD;
        end
      end
      ST_FAIL: begin
        cnt_next = '0;
      end
      default: begin
        state_next = ST_IDLE;
        cnt_next   = '0;
        retry_next = 2'd0;
      end
    endcase
    if (!ENABLE) begin
      state_next = ST_IDLE;
      cnt_next   = '0;
      retry_next = 2'd0;
    end
  end

  assign STATE      = state;
  assign RETRY_CNT  = retry;
  assign FAULT      = (state == ST_FAIL);
  assign PLL_RESETB = (state == ST_WAIT_LOCK) || (state == ST_STABLE) || (state == ST_RUN);

`ifdef PLL_SEQ_BYPASS_ON_FAIL_EN
  // After exhausting retries, fall back to the reference clock through bypass
  assign PLL_BYPASS = (state == ST_FAIL);
  assign CLK_READY  = (state == ST_RUN) || (state == ST_FAIL);
  assign SYS_RESET  = !((state == ST_RUN) || (state == ST_FAIL));
`else
  assign PLL_BYPASS = 1'b0;
  assign CLK_READY  = (state == ST_RUN);
  assign SYS_RESET  = (state != ST_RUN);
`endif

endmodule

`default_nettype wire

// File: tb/tb_pll_lock_sequencer.sv
// ============================================================================
// Module   : tb_pll_lock_sequencer
// Purpose  : Directed self-checking bench for pll_lock_sequencer
//            (honours PLL_SEQ_BYPASS_ON_FAIL_EN when defined).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pll_lock_sequencer;

`ifdef PLL_SEQ_BYPASS_ON_FAIL_EN
  localparam int C_BYP = 1;
`else
  localparam int C_BYP = 0;
`endif

  logic       clk;
  logic       rst;
  logic       enable;
  logic       pll_lock;
  logic       pll_resetb;
  logic       pll_bypass;
  logic       clk_ready;
  logic       sys_reset;
  logic       fault;
  logic [2:0] state;
  logic [1:0] retry_cnt;

  int checks = 0;
  int errors = 0;

  pll_lock_sequencer #(
    .CNT_W               (16),
    .RESET_HOLD_CYCLES   (4),
    .LOCK_TIMEOUT_CYCLES (32),
    .LOCK_STABLE_CYCLES  (8),
    .MAX_RETRIES         (2)
  ) dut (
    .REFERENCECLK (clk),
    .RESET        (rst),
    .ENABLE       (enable),
    .PLL_LOCK     (pll_lock),
    .PLL_RESETB   (pll_resetb),
    .PLL_BYPASS   (pll_bypass),
    .CLK_READY    (clk_ready),
    .SYS_RESET    (sys_reset),
    .FAULT        (fault),
    .STATE        (state),
    .RETRY_CNT    (retry_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int st, input int rb, input int rdy,
                         input int srst, input int flt, input int rty);
    chk({tag, ".state"},  32'(state),      st);
    chk({tag, ".resetb"}, 32'(pll_resetb), rb);
    chk({tag, ".ready"},  32'(clk_ready),  rdy);
    chk({tag, ".sysrst"}, 32'(sys_reset),  srst);
    chk({tag, ".fault"},  32'(fault),      flt);
    chk({tag, ".retry"},  32'(retry_cnt),  rty);
    chk({tag, ".bypass"}, 32'(pll_bypass), (st == 5) ? C_BYP : 0);
  endtask

  initial begin
    rst      = 1'b1;
    enable   = 1'b0;
    pll_lock = 1'b0;
    tick(3);
    chk_all("reset", 0, 0, 0, 1, 0, 0);
    rst = 1'b0;

    // Normal bring-up, ENABLE at c0
    tick(1);
    enable = 1'b1;
    tick(4);  chk_all("hold_c4", 1, 0, 0, 1, 0, 0);
    tick(1);  chk_all("wait_c5", 2, 1, 0, 1, 0, 0);
    tick(10); pll_lock = 1'b1;
    tick(2);  chk("c17_state", 32'(state), 2);
    tick(1);  chk_all("stable_c18", 3, 1, 0, 1, 0, 0);
    tick(7);  chk("c25_state", 32'(state), 3);
    tick(1);  chk_all("run_c26", 4, 1, 1, 0, 0, 0);

    // Lock loss in RUN
    pll_lock = 1'b0;
    tick(2);  chk_all("loss_t2", 4, 1, 1, 0, 0, 0);
    tick(1);  chk_all("loss_t3", 1, 0, 0, 1, 0, 0);
    pll_lock = 1'b1;
    tick(4);  chk("relock_wait", 32'(state), 2);
    tick(1);  chk("relock_stable", 32'(state), 3);
    tick(7);  chk("relock_stable7", 32'(state), 3);
    tick(1);  chk_all("relock_run", 4, 1, 1, 0, 0, 0);

    // One-cycle glitch while STABLE at cnt=5
    enable = 1'b0;
    tick(1);  chk_all("idle_a", 0, 0, 0, 1, 0, 0);
    enable = 1'b1;
    tick(5);  chk("gl_wait", 32'(state), 2);
    tick(1);  chk("gl_stable0", 32'(state), 3);
    tick(5);  pll_lock = 1'b0;
    tick(1);  pll_lock = 1'b1;
    tick(1);  chk("gl_stable7", 32'(state), 3);
    tick(1);  chk_all("gl_back_wait", 2, 1, 0, 1, 0, 0);
    tick(1);  chk("gl_restable", 32'(state), 3);
    tick(7);  chk("gl_restable7", 32'(state), 3);
    tick(1);  chk_all("gl_run", 4, 1, 1, 0, 0, 0);

    // ENABLE drop mid-WAIT_LOCK
    enable = 1'b0;
    tick(1);
    enable   = 1'b1;
    pll_lock = 1'b0;
    tick(5);  chk("en_wait", 32'(state), 2);
    tick(10); chk("en_wait10", 32'(state), 2);
    enable = 1'b0;
    tick(1);  chk_all("en_idle", 0, 0, 0, 1, 0, 0);

    // Timeouts with LOCK held low
    enable = 1'b1;
    tick(5);  chk_all("rt_wait0", 2, 1, 0, 1, 0, 0);
    tick(31); chk("rt_wait0_end", 32'(state), 2);
    tick(1);  chk_all("rt_hold1", 1, 0, 0, 1, 0, 1);
    tick(3);  chk("rt_hold1_end", 32'(pll_resetb), 0);
    tick(1);  chk_all("rt_wait1", 2, 1, 0, 1, 0, 1);
    tick(31); chk("rt_wait1_end", 32'(state), 2);
    tick(1);  chk_all("rt_hold2", 1, 0, 0, 1, 0, 2);
    tick(4);  chk_all("rt_wait2", 2, 1, 0, 1, 0, 2);
    tick(31); chk("rt_wait2_end", 32'(state), 2);
    tick(1);  chk_all("rt_fail", 5, 0, C_BYP, 1 - C_BYP, 1, 2);
    pll_lock = 1'b1;
    tick(6);  chk_all("rt_fail_hold", 5, 0, C_BYP, 1 - C_BYP, 1, 2);
    enable = 1'b0;
    tick(1);  chk_all("rt_cleared", 0, 0, 0, 1, 0, 0);

    // Asynchronous reset mid-RUN
    enable = 1'b1;
    tick(13); chk("ar_stable", 32'(state), 3);
    tick(1);  chk_all("ar_run", 4, 1, 1, 0, 0, 0);
    #2;
    rst = 1'b1;
    #1;
    chk_all("ar_async", 0, 0, 0, 1, 0, 0);
    tick(1);
    rst = 1'b0;
    tick(1);  chk("ar_restart", 32'(state), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
